// File: rtl/tank_pkg.sv
// Shared types and constants for the player tank controllers.
// Holds state encoding, default key bindings and screen limits.
package tank_pkg;

    typedef enum logic [1:0] {
        ALIVE,
        DEAD,
        FROZEN
    } tank_state_t;

    localparam int POS_W = 13;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int X_MAX_DEF = SCREEN_W - 11;
    localparam int Y_MAX_DEF = SCREEN_H - 11;

    localparam logic [7:0] P1_KEY_FWD  = 8'h52;
    localparam logic [7:0] P1_KEY_BACK = 8'h51;
    localparam logic [7:0] P1_KEY_CW   = 8'h50;
    localparam logic [7:0] P1_KEY_CCW  = 8'h4F;
    localparam logic [7:0] P1_KEY_FIRE = 8'h2C;

    localparam logic [7:0] P2_KEY_FWD  = 8'h1A;
    localparam logic [7:0] P2_KEY_BACK = 8'h16;
    localparam logic [7:0] P2_KEY_CW   = 8'h07;
    localparam logic [7:0] P2_KEY_CCW  = 8'h04;
    localparam logic [7:0] P2_KEY_FIRE = 8'h28;

endpackage

// File: rtl/tank_if.sv
// Tank controller bus: inputs from keyboard, walls and trig LUT,
// outputs to the bullet, collision and drawing logic.
interface tank_if;
    import tank_pkg::*;

    logic [31:0] keycode;
    logic        hit;
    logic [1:0]  game_end;
    logic        wall_any;
    logic [7:0]  sin;
    logic [7:0]  cos;
    logic [9:0]  tank_x;
    logic [9:0]  tank_y;
    logic [12:0] step_x;
    logic [12:0] step_y;
    logic [5:0]  angle;
    logic        shoot;
    logic        alive;

    modport master (
        output keycode, hit, game_end, wall_any, sin, cos,
        input  tank_x, tank_y, step_x, step_y, angle, shoot, alive
    );

    modport slave (
        input  keycode, hit, game_end, wall_any, sin, cos,
        output tank_x, tank_y, step_x, step_y, angle, shoot, alive
    );

endinterface

// File: rtl/tank_key_decode.sv
// Matches the four keycode slots against the five bound keys.
// A key counts as held if any slot carries its code.
module tank_key_decode
    import tank_pkg::*;
#(
    parameter logic [7:0] KEY_FWD  = P1_KEY_FWD,
    parameter logic [7:0] KEY_BACK = P1_KEY_BACK,
    parameter logic [7:0] KEY_CW   = P1_KEY_CW,
    parameter logic [7:0] KEY_CCW  = P1_KEY_CCW,
    parameter logic [7:0] KEY_FIRE = P1_KEY_FIRE
) (
    input  logic [31:0] keycode_i,
    output logic        fwd_o,
    output logic        back_o,
    output logic        cw_o,
    output logic        ccw_o,
    output logic        fire_o
);

    // Scan every slot for each binding.
    always_comb begin
        fwd_o  = 1'b0;
        back_o = 1'b0;
        cw_o   = 1'b0;
        ccw_o  = 1'b0;
        fire_o = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (keycode_i[8*i +: 8] == KEY_FWD)  fwd_o  = 1'b1;
            if (keycode_i[8*i +: 8] == KEY_BACK) back_o = 1'b1;
            if (keycode_i[8*i +: 8] == KEY_CW)   cw_o   = 1'b1;
            if (keycode_i[8*i +: 8] == KEY_CCW)  ccw_o  = 1'b1;
            if (keycode_i[8*i +: 8] == KEY_FIRE) fire_o = 1'b1;
        end
    end

endmodule

// File: rtl/tank_ctrl.sv
// Per-player tank: movement, turning, edge-triggered fire with
// cooldown, timed respawn after a hit and freeze on game end.
module tank_ctrl
    import tank_pkg::*;
#(
    parameter logic [7:0] KEY_FWD  = P1_KEY_FWD,
    parameter logic [7:0] KEY_BACK = P1_KEY_BACK,
    parameter logic [7:0] KEY_CW   = P1_KEY_CW,
    parameter logic [7:0] KEY_CCW  = P1_KEY_CCW,
    parameter logic [7:0] KEY_FIRE = P1_KEY_FIRE,
    parameter int FRAC_BITS      = 3,
    parameter int SPEED          = 16,
    parameter int ANGLE_STEPS    = 45,
    parameter int SPAWN_X        = 300,
    parameter int SPAWN_Y        = 250,
    parameter int SPAWN_ANGLE    = 0,
    parameter int FIRE_COOLDOWN  = 30,
    parameter int RESPAWN_FRAMES = 60,
    parameter int X_MAX          = X_MAX_DEF,
    parameter int Y_MAX          = Y_MAX_DEF
) (
    input logic   frame_clk,
    input logic   Reset,
    tank_if.slave bus
);

    localparam logic [POS_W-1:0] SPX = POS_W'(SPAWN_X << FRAC_BITS);
    localparam logic [POS_W-1:0] SPY = POS_W'(SPAWN_Y << FRAC_BITS);
    localparam logic [5:0]  SPA       = 6'(SPAWN_ANGLE);
    localparam logic [5:0]  A_LAST    = 6'(ANGLE_STEPS - 1);
    localparam logic [15:0] COOL_LOAD = 16'(FIRE_COOLDOWN - 1);
    localparam logic [15:0] RESP_LOAD = 16'(RESPAWN_FRAMES - 1);

    tank_state_t             state_q;
    logic [POS_W-1:0]        pos_x_q, pos_y_q, pos_x_d, pos_y_d;
    logic signed [POS_W-1:0] step_x_q, step_y_q, step_x_d, step_y_d;
    logic [5:0]              angle_q, angle_d;
    logic [15:0]             cool_q, resp_q;
    logic                    fire_prev_q, shoot_q, alive_q;

    logic k_fwd, k_back, k_cw, k_ccw, k_fire;
    logic [13:0] mul_x, mul_y;
    logic [6:0]  dx, dy;
    logic signed [POS_W-1:0] fx, fy;

    tank_key_decode #(
        .KEY_FWD  (KEY_FWD),
        .KEY_BACK (KEY_BACK),
        .KEY_CW   (KEY_CW),
        .KEY_CCW  (KEY_CCW),
        .KEY_FIRE (KEY_FIRE)
    ) u_keys (
        .keycode_i (bus.keycode),
        .fwd_o     (k_fwd),
        .back_o    (k_back),
        .cw_o      (k_cw),
        .ccw_o     (k_ccw),
        .fire_o    (k_fire)
    );

    // Add a signed step and pin the result to the screen edges.
    function automatic logic [POS_W-1:0] clamp(
        input logic [POS_W-1:0]        p,
        input logic signed [POS_W-1:0] s,
        input int                      lim
    );
        int n;
        n = int'(p) + int'(s);
        if (n < 0) return '0;
        if ((n >>> FRAC_BITS) > lim) return POS_W'(lim << FRAC_BITS);
        return POS_W'(n);
    endfunction

    // Candidate step, heading and clamped position for an alive frame.
    always_comb begin
        mul_x = 14'(SPEED) * {7'd0, bus.cos[6:0]};
        mul_y = 14'(SPEED) * {7'd0, bus.sin[6:0]};
        dx = 7'(mul_x >> 7);
        dy = 7'(mul_y >> 7);
        fx = $signed({6'd0, dx});
        fy = $signed({6'd0, dy});
        if (bus.cos[7])  fx = -fx;
        if (!bus.sin[7]) fy = -fy;
        step_x_d = '0;
        step_y_d = '0;
        angle_d  = angle_q;
        if (k_fwd) begin
            step_x_d = fx;
            step_y_d = fy;
        end else if (k_back) begin
            step_x_d = -fx;
            step_y_d = -fy;
        end else if (!bus.wall_any) begin
            if (k_cw)
                angle_d = (angle_q == A_LAST) ? 6'd0 : angle_q + 6'd1;
            else if (k_ccw)
                angle_d = (angle_q == 6'd0) ? A_LAST : angle_q - 6'd1;
        end
        if ((k_fwd || k_back) && bus.wall_any) begin
            step_x_d = -(step_x_d <<< 1);
            step_y_d = -(step_y_d <<< 1);
        end
        pos_x_d = clamp(pos_x_q, step_x_d, X_MAX);
        pos_y_d = clamp(pos_y_q, step_y_d, Y_MAX);
    end

    // Tank state machine with registered outputs.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ALIVE;
            pos_x_q     <= SPX;
            pos_y_q     <= SPY;
            angle_q     <= SPA;
            step_x_q    <= '0;
            step_y_q    <= '0;
            cool_q      <= '0;
            resp_q      <= '0;
            fire_prev_q <= 1'b0;
            shoot_q     <= 1'b0;
            alive_q     <= 1'b1;
        end else begin
            fire_prev_q <= k_fire;
            shoot_q     <= 1'b0;
            if (cool_q != 16'd0) cool_q <= cool_q - 16'd1;
            if (bus.game_end != 2'd0) begin
                state_q  <= FROZEN;
                pos_x_q  <= SPX;
                pos_y_q  <= SPY;
                angle_q  <= SPA;
                step_x_q <= '0;
                step_y_q <= '0;
                alive_q  <= 1'b1;
            end else begin
                unique case (state_q)
                    ALIVE: begin
                        if (bus.hit) begin
                            state_q  <= DEAD;
                            alive_q  <= 1'b0;
                            resp_q   <= RESP_LOAD;
                            step_x_q <= '0;
                            step_y_q <= '0;
                        end else begin
                            pos_x_q  <= pos_x_d;
                            pos_y_q  <= pos_y_d;
                            step_x_q <= step_x_d;
                            step_y_q <= step_y_d;
                            angle_q  <= angle_d;
                            if (k_fire && !fire_prev_q && cool_q == 16'd0) begin
                                shoot_q <= 1'b1;
                                cool_q  <= COOL_LOAD;
                            end
                        end
                    end
                    DEAD: begin
                        if (resp_q == 16'd0) begin
                            state_q <= ALIVE;
                            pos_x_q <= SPX;
                            pos_y_q <= SPY;
                            angle_q <= SPA;
                            cool_q  <= '0;
                            alive_q <= 1'b1;
                        end else begin
                            resp_q <= resp_q - 16'd1;
                        end
                    end
                    FROZEN: begin
                        state_q  <= ALIVE;
                        pos_x_q  <= SPX;
                        pos_y_q  <= SPY;
                        angle_q  <= SPA;
                        step_x_q <= '0;
                        step_y_q <= '0;
                        alive_q  <= 1'b1;
                    end
                    default: state_q <= ALIVE;
                endcase
            end
        end
    end

    assign bus.tank_x = 10'(pos_x_q >> FRAC_BITS);
    assign bus.tank_y = 10'(pos_y_q >> FRAC_BITS);
    assign bus.step_x = step_x_q;
    assign bus.step_y = step_y_q;
    assign bus.angle  = angle_q;
    assign bus.shoot  = shoot_q;
    assign bus.alive  = alive_q;

endmodule

// File: tb/tb_tank_ctrl.sv
// Directed bench for tank_ctrl with default player-1 parameters.
// Expected values are hand-computed from the tank behaviour.
module tb_tank_ctrl;

    logic frame_clk;
    logic Reset;
    int   checks;
    int   failures;
    int   pulses;
    logic dead_ok;

    tank_if bus ();

    tank_ctrl dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus.slave)
    );

    initial begin
        frame_clk = 1'b0;
        forever #5 frame_clk = ~frame_clk;
    end

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        Reset        = 1'b1;
        bus.keycode  = 32'h0;
        bus.hit      = 1'b0;
        bus.game_end = 2'd0;
        bus.wall_any = 1'b0;
        bus.sin      = 8'h00;
        bus.cos      = 8'h7F;
        #12;
        chk("rst_x", 32'(bus.tank_x), 32'd300);
        chk("rst_y", 32'(bus.tank_y), 32'd250);
        chk("rst_angle", 32'(bus.angle), 32'd0);
        chk("rst_alive", 32'(bus.alive), 32'd1);
        chk("rst_shoot", 32'(bus.shoot), 32'd0);
        chk("rst_step", 32'(bus.step_x), 32'd0);
        Reset = 1'b0;

        // forward along +X: 15 sub-pixels per frame
        bus.keycode = 32'h0000_0052;
        tick();
        chk("fwd_step_x", 32'(bus.step_x), 32'd15);
        chk("fwd_step_y", 32'(bus.step_y), 32'd0);
        repeat (7) tick();
        chk("fwd8_x", 32'(bus.tank_x), 32'd315);
        chk("fwd8_y", 32'(bus.tank_y), 32'd250);
        bus.keycode = 32'h0;
        tick();
        chk("idle_step", 32'(bus.step_x), 32'd0);

        // turning with wrap
        bus.keycode = 32'h0000_4F00;
        tick();
        chk("ccw_wrap", 32'(bus.angle), 32'd44);
        bus.keycode = 32'h0000_0050;
        tick();
        chk("cw_wrap", 32'(bus.angle), 32'd0);
        tick();
        chk("cw_one", 32'(bus.angle), 32'd1);

        // fire held 40 frames: single pulse
        bus.keycode = 32'h0000_002C;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            pulses += int'(bus.shoot);
        end
        chk("fire_held", 32'(pulses), 32'd1);
        bus.keycode = 32'h0;
        tick();
        bus.keycode = 32'h0000_002C;
        tick();
        chk("fire_shot", 32'(bus.shoot), 32'd1);
        tick();
        chk("fire_one_frame", 32'(bus.shoot), 32'd0);
        bus.keycode = 32'h0;
        repeat (8) tick();
        bus.keycode = 32'h0000_002C;
        tick();
        chk("fire_cooldown_drop", 32'(bus.shoot), 32'd0);
        bus.keycode = 32'h0;
        repeat (19) tick();
        bus.keycode = 32'h0000_002C;
        tick();
        chk("fire_after_cooldown", 32'(bus.shoot), 32'd1);

        // hit: 60 dead frames, keys ignored, respawn
        bus.keycode = 32'h0000_0052;
        bus.hit = 1'b1;
        tick();
        bus.hit = 1'b0;
        chk("hit_alive", 32'(bus.alive), 32'd0);
        chk("hit_step", 32'(bus.step_x), 32'd0);
        dead_ok = 1'b1;
        for (int i = 0; i < 59; i++) begin
            tick();
            if (bus.alive !== 1'b0 || bus.tank_x !== 10'd315) dead_ok = 1'b0;
        end
        chk("dead_hold", 32'(dead_ok), 32'd1);
        tick();
        chk("respawn_alive", 32'(bus.alive), 32'd1);
        chk("respawn_x", 32'(bus.tank_x), 32'd300);
        chk("respawn_y", 32'(bus.tank_y), 32'd250);
        chk("respawn_angle", 32'(bus.angle), 32'd0);

        // game_end beats hit
        bus.game_end = 2'd2;
        bus.hit = 1'b1;
        tick();
        chk("frozen_alive", 32'(bus.alive), 32'd1);
        chk("frozen_x", 32'(bus.tank_x), 32'd300);
        bus.hit = 1'b0;
        tick();
        chk("frozen_hold_x", 32'(bus.tank_x), 32'd300);
        chk("frozen_step", 32'(bus.step_x), 32'd0);
        bus.game_end = 2'd0;
        bus.keycode = 32'h0;
        tick();
        chk("unfreeze_alive", 32'(bus.alive), 32'd1);
        chk("unfreeze_x", 32'(bus.tank_x), 32'd300);
        bus.keycode = 32'h0000_0052;
        tick();
        chk("unfreeze_move", 32'(bus.tank_x), 32'd301);

        // wall push-back: -2 x step
        bus.wall_any = 1'b1;
        tick();
        chk("wall_step", 32'(bus.step_x), 32'(13'h1FE2));
        chk("wall_x", 32'(bus.tank_x), 32'd298);
        bus.keycode = 32'h0000_0050;
        tick();
        chk("wall_no_turn", 32'(bus.angle), 32'd0);
        bus.wall_any = 1'b0;

        // clamp at both X limits
        bus.keycode = 32'h0000_0051;
        repeat (170) tick();
        chk("clamp_low_x", 32'(bus.tank_x), 32'd0);
        chk("back_step", 32'(bus.step_x), 32'(13'h1FF1));
        bus.keycode = 32'h0000_0052;
        repeat (400) tick();
        chk("clamp_high_x", 32'(bus.tank_x), 32'd629);

        // unbound key
        bus.keycode = 32'h0000_0004;
        tick();
        chk("unbound_step", 32'(bus.step_x), 32'd0);

        // heading -Y on screen with fire in slot 3
        bus.cos = 8'h00;
        bus.sin = 8'h7F;
        bus.keycode = 32'h2C00_0052;
        tick();
        chk("y_step", 32'(bus.step_y), 32'(13'h1FF1));
        chk("y_pos", 32'(bus.tank_y), 32'd248);
        chk("slot3_fire", 32'(bus.shoot), 32'd1);

        // async reset aborts cooldown
        Reset = 1'b1;
        #2;
        chk("async_rst_x", 32'(bus.tank_x), 32'd300);
        chk("async_rst_shoot", 32'(bus.shoot), 32'd0);
        Reset = 1'b0;
        tick();
        chk("post_rst_fire", 32'(bus.shoot), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
